// File: rtl/gpio_uart_rx.sv
// 8N1 idle-high serial receiver for the remote controller link. It holds the last
// good byte and clears it to "no buttons" when the link goes quiet.
module gpio_uart_rx #(
    parameter int CLKS_PER_BIT   = 434,
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_stale,
    output logic [2:0] dbg_state
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [BW-1:0] HALF_M1 = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] FULL_M1 = BW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_PRE  = TW'(TIMEOUT_CYCLES - 2);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          rx_m, rx_s;
    logic [BW-1:0] bc_q, bc_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          stale_q, stale_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_m     <= 1'b1;
            rx_s     <= 1'b1;
            state_q  <= IDLE;
            bc_q     <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            stale_q  <= 1'b1;
            to_cnt_q <= '0;
        end else begin
            rx_m     <= i_rx;
            rx_s     <= rx_m;
            state_q  <= state_d;
            bc_q     <= bc_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            stale_q  <= stale_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bc_d     = bc_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;
        stale_d  = stale_q;
        to_cnt_d = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 1'b1;

        // Expiry is evaluated first so a good frame on the same cycle overrides it.
        if (to_cnt_q == TO_PRE) begin
            data_d  = 8'h00;
            stale_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    bc_d    = '0;
                end
            end
            START: begin
                if (bc_q == HALF_M1) begin
                    bc_d    = '0;
                    idx_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    bc_d = bc_q + 1'b1;
                end
            end
            DATA: begin
                if (bc_q == FULL_M1) begin
                    bc_d           = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) state_d = STOP;
                    else               idx_d   = idx_q + 1'b1;
                end else begin
                    bc_d = bc_q + 1'b1;
                end
            end
            STOP: begin
                if (bc_q == FULL_M1) begin
                    bc_d = '0;
                    if (rx_s) begin
                        data_d   = shift_q;
                        valid_d  = 1'b1;
                        stale_d  = 1'b0;
                        to_cnt_d = '0;
                        state_d  = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    bc_d = bc_q + 1'b1;
                end
            end
            BREAK: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // o_valid is a one-cycle strobe with no ready: the consumer must take o_data that cycle.
    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;
    assign o_stale     = stale_q;
    assign dbg_state   = state_q;

endmodule
